// File: rtl/bcd_display_scanner_pkg.sv
// rtl/bcd_display_scanner_pkg.sv - shared seven-segment glyph constants and types
package bcd_display_scanner_pkg;

  typedef logic [6:0] seg_t;

  // Glyphs are {g,f,e,d,c,b,a}, active low.
  localparam seg_t SEG_ZERO  = 7'h40;
  localparam seg_t SEG_ONE   = 7'h79;
  localparam seg_t SEG_TWO   = 7'h24;
  localparam seg_t SEG_THREE = 7'h30;
  localparam seg_t SEG_FOUR  = 7'h19;
  localparam seg_t SEG_FIVE  = 7'h12;
  localparam seg_t SEG_SIX   = 7'h02;
  localparam seg_t SEG_SEVEN = 7'h78;
  localparam seg_t SEG_EIGHT = 7'h00;
  localparam seg_t SEG_NINE  = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg_n.sv
// rtl/bcd_display_scanner_bcd_to_seg_n.sv - combinational BCD to active-low segment decoder
module bcd_to_seg_n
  import bcd_display_scanner_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] digit,
  input  logic            blank,
  output logic [6:0]      seg_n
);

  // Blank wins over the digit; any non-BCD code falls through to the dash glyph.
  always_comb begin
    seg_n = SEG_DASH;
    if (blank) begin
      seg_n = SEG_BLANK;
    end else begin
      case (int'(digit))
        0:       seg_n = SEG_ZERO;
        1:       seg_n = SEG_ONE;
        2:       seg_n = SEG_TWO;
        3:       seg_n = SEG_THREE;
        4:       seg_n = SEG_FOUR;
        5:       seg_n = SEG_FIVE;
        6:       seg_n = SEG_SIX;
        7:       seg_n = SEG_SEVEN;
        8:       seg_n = SEG_EIGHT;
        9:       seg_n = SEG_NINE;
        default: seg_n = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed seven-segment scanner with guard cycles
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SIZE     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DIGITS*SIZE-1:0] digits_in,
  input  logic                   blank_lz,
  output logic [6:0]             seg_n,
  output logic [DIGITS-1:0]      an_n
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIGITS*SIZE-1:0] shadow;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic                   tick;
  logic [SIZE-1:0]        cur_digit;
  logic                   cur_blank;
  logic                   upper_zero;
  logic [6:0]             dec_seg;
  logic [6:0]             seg_next;
  logic [DIGITS-1:0]      an_next;

  assign tick = (cnt == CNT_LAST);

  // Snapshot the counter outputs on load; reset dominates so a load during reset is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= digits_in;
    end
  end

  // Slot prescaler and digit index; idx moves on the last cycle of each slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Select the digit at idx and decide leading-zero blanking by scanning from the top digit down.
  always_comb begin
    cur_digit  = '0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (shadow[i*SIZE +: SIZE] == '0);
      if (idx == IDX_W'(i)) begin
        cur_digit = shadow[i*SIZE +: SIZE];
        cur_blank = blank_lz & (i != 0) & upper_zero;
      end
    end
  end

  bcd_to_seg_n #(
    .SIZE (SIZE)
  ) u_bcd_to_seg_n (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg_n (dec_seg)
  );

  // First cycle of every slot is dark so the previous digit never ghosts onto the next anode.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    if (cnt != '0) begin
      an_next  = ~(DIGITS'(1) << idx);
      seg_next = dec_seg;
    end
  end

  // Register the pins so the display sees glitch-free segment and anode drives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= an_next;
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

  logic        clock;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;

  bcd_display_scanner #(
    .DIGITS   (4),
    .SIZE     (4),
    .SCAN_DIV (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .digits_in (digits_in),
    .blank_lz  (blank_lz),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One active edge, then return at the following falling edge where outputs are sampled.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    edges++;
  endtask

  // Advance until the next edge is the first (dark) edge of slot 0, then check a whole frame.
  task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input bit onehot);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    exp_an[0]  = 4'hE; exp_an[1] = 4'hD; exp_an[2] = 4'hB; exp_an[3] = 4'h7;
    while ((edges % 16) != 0) step();
    for (int k = 0; k < 16; k++) begin
      step();
      if ((k % 4) == 0) begin
        check($sformatf("%s an k%0d", tag, k), 16'(an_n), 16'h000F);
        check($sformatf("%s seg k%0d", tag, k), 16'(seg_n), 16'h007F);
      end else begin
        check($sformatf("%s an k%0d", tag, k), 16'(an_n), 16'(exp_an[k/4]));
        check($sformatf("%s seg k%0d", tag, k), 16'(seg_n), 16'(exp_seg[k/4]));
      end
      if (onehot) begin
        check($sformatf("%s onehot k%0d", tag, k), 16'($countones(~an_n) <= 1), 16'd1);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] value);
    digits_in = value;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    blank_lz  = 1'b0;
    step();
    step();
    check("reset an", 16'(an_n), 16'h000F);
    check("reset seg", 16'(seg_n), 16'h007F);

    reset = 1'b0;
    edges = 0;
    step();
    check("rel edge1 an", 16'(an_n), 16'h000F);
    check("rel edge1 seg", 16'(seg_n), 16'h007F);
    step();
    check("rel edge2 an", 16'(an_n), 16'h000E);
    check("rel edge2 seg", 16'(seg_n), 16'h0040);

    // Asynchronous reset mid-slot, with a load attempted while reset is held.
    #2 reset = 1'b1;
    #1;
    check("async reset an", 16'(an_n), 16'h000F);
    check("async reset seg", 16'(seg_n), 16'h007F);
    @(negedge clock);
    digits_in = 16'h1234;
    load      = 1'b1;
    step();
    step();
    load  = 1'b0;
    reset = 1'b0;
    edges = 0;
    step();
    check("post reset edge1 an", 16'(an_n), 16'h000F);
    step();
    check("post reset edge2 an", 16'(an_n), 16'h000E);
    check("load in reset ignored", 16'(seg_n), 16'h0040);

    // Scan order.
    do_load(16'h1234);
    run_frame("scan1234", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0042);
    run_frame("lz0042", 7'h24, 7'h19, 7'h7F, 7'h7F, 1'b0);
    do_load(16'h0000);
    run_frame("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0);

    // Error glyph with guard and one-hot anode checks.
    blank_lz = 1'b0;
    do_load(16'h0A0F);
    run_frame("err0A0F", 7'h3F, 7'h40, 7'h3F, 7'h40, 1'b1);

    // Load while digit 0 is lit.
    do_load(16'h0004);
    while ((edges % 16) != 0) step();
    step();
    check("midload dark", 16'(an_n), 16'h000F);
    step();
    check("midload before seg", 16'(seg_n), 16'h0019);
    digits_in = 16'h0007;
    load      = 1'b1;
    step();
    load      = 1'b0;
    check("midload capture edge seg", 16'(seg_n), 16'h0019);
    step();
    check("midload after seg", 16'(seg_n), 16'h0078);
    check("midload after an", 16'(an_n), 16'h000E);

    // Three frames back to back: slot boundaries must stay on the 16-cycle grid.
    run_frame("wrap1", 7'h78, 7'h40, 7'h40, 7'h40, 1'b1);
    run_frame("wrap2", 7'h78, 7'h40, 7'h40, 7'h40, 1'b1);
    run_frame("wrap3", 7'h78, 7'h40, 7'h40, 7'h40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
